scrambler_rate_ctrl: RTL and testbench
======================================

// Module: scrambler_rate_ctrl
// PURPOSE
//  Sequences one scrambler frame: latches config on start, pulses a seed load,
//  then issues one bit-enable strobe every div_ratio clocks for frame_len bits.
//  Replaces the free-running fixed clock division with a programmable prescaler
//  under start/abort/done control. Sits between the link controller and the scrambler datapath.
// PARAMETERS
//  DIV_W   8   width of div_ratio / prescale counter
//  LEN_W   16  width of frame_len / bit_idx
//  SEED_W  7   scrambler LFSR seed width
// PORTS
//  clk        in   1       single clock; all logic on posedge clk
//  rst        in   1       synchronous, active-high reset
//  start      in   1       frame request; sampled only in IDLE
//  abort      in   1       cancel current frame; highest priority after rst
//  div_ratio  in   DIV_W   clocks per scrambler bit, valid 1..2^DIV_W-1
//  frame_len  in   LEN_W   bits per frame, valid 1..2^LEN_W-1
//  seed_in    in   SEED_W  LFSR seed for this frame
//  busy       out  1       high in LOAD, RUN, DONE
//  seed_load  out  1       1-cycle pulse in LOAD; scrambler loads seed_out
//  seed_out   out  SEED_W  latched seed; valid while busy
//  bit_en     out  1       1-cycle strobe; scrambler advances one bit
//  bit_idx    out  LEN_W   index of the bit strobed by the current bit_en (0-based)
//  done       out  1       1-cycle pulse after the last bit
//  cfg_err    out  1       1-cycle pulse: start with div_ratio==0 or frame_len==0
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; prescaler, bit counter, config regs 0.
//  - FSM IDLE->LOAD->RUN->DONE->IDLE. All outputs registered.
//  - IDLE, start=1, config valid: latch div_ratio/frame_len/seed_in; go LOAD.
//  - IDLE, start=1, config invalid: cfg_err pulse next cycle; stay IDLE; busy stays 0.
//  - LOAD: exactly 1 cycle; seed_load=1. Next state RUN; prescaler=0, bit counter=0.
//  - RUN: prescaler counts 0..div-1 and wraps. bit_en=1 in the cycle after it reaches div-1.
//    bit_idx = bit counter value for that strobe; counter increments after each strobe.
//    After the strobe with bit_idx==frame_len-1, go DONE.
//  - DONE: 1 cycle; done=1. Then IDLE. start is accepted again the cycle after DONE.
//  - Timing: start sampled in cycle 0 -> seed_load in cycle 1.
//    bit_en in cycles 1+div*i, for i=1..len. done in cycle 2+div*len.
//  - div_ratio==1: bit_en is high on every RUN cycle.
//  - start while busy: ignored, not queued. Input changes while busy: no effect (latched).
//  - abort in LOAD/RUN/DONE: next cycle IDLE; all outputs 0; no done pulse.
//    abort in IDLE: no effect. abort and start in the same IDLE cycle: start is ignored.
//  - rst mid-frame: same result as reset.
//  - Counters never wrap in a legal frame (frame_len <= 2^LEN_W-1).
// CONFIGURATION
//  SCR_DIVCLK_OUT_EN defined: adds output div_clk (1 bit).
//    div_clk resets to 0 and toggles on every bit_en cycle.
//    It is forced to 0 in the cycle after DONE or abort.
//  SCR_DIVCLK_OUT_EN undefined: no div_clk port and no toggle register; all other behaviour identical.
// STRUCTURE
//  - Package scr_ctrl_pkg: state enum (IDLE, LOAD, RUN, DONE); default widths DIV_W/LEN_W/SEED_W.
//  - Sub-module scr_tick_gen: prescale counter.
//    Inputs: clk, rst, clr, en, div. Output: tick (1-cycle pulse every div enabled cycles).
//  - Top level holds the FSM, config latches, bit counter, and the optional div_clk.
// TESTING
//  1. div=4, len=3, seed=7'h5A: seed_load@1 (seed_out=5A); bit_en@5,9,13 (idx 0,1,2);
//     done@14; busy@1..14.
//  2. div=1, len=2: bit_en@2,3; done@4; back-to-back start@5 accepted, seed_load@6.
//  3. start with div=0, then with len=0: cfg_err one cycle later each time; busy never rises.
//  4. div=3, len=10, abort@8: all outputs 0 from cycle 9; no done; new start@10 runs a full frame.
//  5. start pulsed @3,6 during an active frame: ignored; timing identical to the single-start run.
//  6. rst@7 mid-frame: state IDLE and all outputs 0 from cycle 8.
//     With SCR_DIVCLK_OUT_EN, div_clk toggles on each bit_en of test 1 and reads 0 after done.

Source files
------------

// File: rtl/scr_ctrl_pkg.sv
// ============================================================================
// Module : scr_ctrl_pkg
// Brief  : Shared state encoding and default widths for the scrambler rate controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
package scr_ctrl_pkg;

  localparam int DIV_W_DEF  = 8;
  localparam int LEN_W_DEF  = 16;
  localparam int SEED_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/scr_tick_gen.sv
// ============================================================================
// Module : scr_tick_gen
// Brief  : Prescale counter; o_tick pulses on every i_div-th enabled cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
module scr_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == i_div - DIV_W'(1));
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/scrambler_rate_ctrl.sv
// ============================================================================
// Module : scrambler_rate_ctrl
// Brief  : Frame sequencer: latches config, pulses seed load, strobes bits at a
//          programmable rate. Optional div_clk output via SCR_DIVCLK_OUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
module scrambler_rate_ctrl #(
  parameter int DIV_W  = scr_ctrl_pkg::DIV_W_DEF,
  parameter int LEN_W  = scr_ctrl_pkg::LEN_W_DEF,
  parameter int SEED_W = scr_ctrl_pkg::SEED_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DIV_W-1:0]  i_div_ratio,
  input  logic [LEN_W-1:0]  i_frame_len,
  input  logic [SEED_W-1:0] i_seed_in,
  output logic              o_busy,
  output logic              o_seed_load,
  output logic [SEED_W-1:0] o_seed_out,
  output logic              o_bit_en,
  output logic [LEN_W-1:0]  o_bit_idx,
  output logic              o_done,
  output logic              o_cfg_err
`ifdef SCR_DIVCLK_OUT_EN
  ,
  output logic              o_div_clk
`endif
);
  import scr_ctrl_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [LEN_W-1:0]  r_len;
  logic [SEED_W-1:0] r_seed;
  logic [LEN_W-1:0]  r_bits;
  logic [LEN_W-1:0]  w_bits_nxt;
  logic [LEN_W-1:0]  w_bit_idx_nxt;
  logic              w_bit_en_nxt;
  logic              w_cfg_err_nxt;
  logic              w_latch;
  logic              w_tick_clr;
  logic              w_tick_en;
  logic              w_tick;

  // Enabled from LOAD so the first strobe lands div cycles after seed_load.
  scr_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tick_clr),
    .i_en   (w_tick_en),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_bits_nxt    = r_bits;
    w_bit_en_nxt  = 1'b0;
    w_bit_idx_nxt = '0;
    w_cfg_err_nxt = 1'b0;
    w_latch       = 1'b0;
    w_tick_clr    = 1'b0;
    w_tick_en     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_clr = 1'b1;
        w_bits_nxt = '0;
        if (i_start && !i_abort) begin
          if (i_div_ratio != '0 && i_frame_len != '0) begin
            w_state_nxt = LOAD;
            w_latch     = 1'b1;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        w_tick_en   = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_tick_en = 1'b1;
        if (o_bit_en && o_bit_idx == r_len - LEN_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_tick && r_bits != r_len) begin
      w_bit_en_nxt  = 1'b1;
      w_bit_idx_nxt = r_bits;
      w_bits_nxt    = r_bits + LEN_W'(1);
    end
    if (i_abort && r_state != IDLE) begin
      w_state_nxt   = IDLE;
      w_bit_en_nxt  = 1'b0;
      w_bit_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_len       <= '0;
      r_seed      <= '0;
      r_bits      <= '0;
      o_busy      <= 1'b0;
      o_seed_load <= 1'b0;
      o_bit_en    <= 1'b0;
      o_bit_idx   <= '0;
      o_done      <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bits      <= w_bits_nxt;
      o_busy      <= (w_state_nxt != IDLE);
      o_seed_load <= (w_state_nxt == LOAD);
      o_bit_en    <= w_bit_en_nxt;
      o_bit_idx   <= w_bit_idx_nxt;
      o_done      <= (w_state_nxt == DONE);
      o_cfg_err   <= w_cfg_err_nxt;
      if (w_latch) begin
        r_div  <= i_div_ratio;
        r_len  <= i_frame_len;
        r_seed <= i_seed_in;
      end else if (w_state_nxt == IDLE) begin
        r_div  <= '0;
        r_len  <= '0;
        r_seed <= '0;
      end
    end
  end

  assign o_seed_out = r_seed;

`ifdef SCR_DIVCLK_OUT_EN
  logic r_div_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_clk <= 1'b0;
    end else if (w_state_nxt == IDLE) begin
      r_div_clk <= 1'b0;
    end else if (w_bit_en_nxt) begin
      r_div_clk <= ~r_div_clk;
    end
  end

  assign o_div_clk = r_div_clk;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scrambler_rate_ctrl.sv
// ============================================================================
// Module : tb_scrambler_rate_ctrl
// Brief  : Self-checking bench for scrambler_rate_ctrl against a timing-formula model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
module tb_scrambler_rate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_abort;
  logic [7:0]  i_div_ratio;
  logic [15:0] i_frame_len;
  logic [6:0]  i_seed_in;
  logic        o_busy;
  logic        o_seed_load;
  logic [6:0]  o_seed_out;
  logic        o_bit_en;
  logic [15:0] o_bit_idx;
  logic        o_done;
  logic        o_cfg_err;
`ifdef SCR_DIVCLK_OUT_EN
  logic        o_div_clk;
`endif

  always #5 clk = ~clk;

  scrambler_rate_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_div_ratio (i_div_ratio),
    .i_frame_len (i_frame_len),
    .i_seed_in   (i_seed_in),
    .o_busy      (o_busy),
    .o_seed_load (o_seed_load),
    .o_seed_out  (o_seed_out),
    .o_bit_en    (o_bit_en),
    .o_bit_idx   (o_bit_idx),
    .o_done      (o_done),
    .o_cfg_err   (o_cfg_err)
`ifdef SCR_DIVCLK_OUT_EN
    ,
    .o_div_clk   (o_div_clk)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: one accepted frame described by its start cycle and latched config.
  bit       m_act = 1'b0;
  int       m_t0  = 0;
  int       m_div = 1;
  int       m_len = 1;
  logic [6:0] m_seed = '0;
  bit       m_cfg = 1'b0;

  bit         log_on = 1'b0;
  int         log_base = 0;
  int         q_ben[$];
  int         q_done[$];
  int         q_sl[$];
  logic [6:0] seen_seed = '0;

  function automatic int frame_end();
    return m_t0 + 2 + m_div * m_len;
  endfunction

  function automatic bit m_busy(input int n);
    return m_act && (n >= m_t0 + 1) && (n <= frame_end());
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int got[$], input int exp[$]);
    bit bad;
    bad = (got.size() != exp.size());
    if (!bad) begin
      foreach (exp[i]) if (got[i] != exp[i]) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got %0d events (first %0d) expected %0d events (first %0d)", nm,
               got.size(), (got.size() > 0) ? got[0] : -1, exp.size(), exp[0]);
    end
  endtask

  task automatic check_cycle();
    int n;
    int k;
    int nb;
    bit b;
    bit ben;
    int idx;
    n   = cyc;
    b   = m_busy(n);
    k   = n - 1 - m_t0;
    ben = 1'b0;
    idx = 0;
    nb  = 0;
    if (b) begin
      ben = (k > 0) && (k % m_div == 0) && (k / m_div <= m_len);
      idx = ben ? (k / m_div - 1) : 0;
      nb  = (k / m_div > m_len) ? m_len : k / m_div;
    end
    chk("busy", 32'(o_busy), 32'(b));
    chk("seed_load", 32'(o_seed_load), 32'(b && k == 0));
    chk("seed_out", 32'(o_seed_out), b ? 32'(m_seed) : 32'd0);
    chk("bit_en", 32'(o_bit_en), 32'(ben));
    if (ben || !b) chk("bit_idx", 32'(o_bit_idx), 32'(idx));
    chk("done", 32'(o_done), 32'(b && n == frame_end()));
    chk("cfg_err", 32'(o_cfg_err), 32'(m_cfg));
`ifdef SCR_DIVCLK_OUT_EN
    chk("div_clk", 32'(o_div_clk), 32'(nb % 2));
`endif
    if (log_on) begin
      if (o_bit_en === 1'b1)    q_ben.push_back(cyc - log_base);
      if (o_done === 1'b1)      q_done.push_back(cyc - log_base);
      if (o_seed_load === 1'b1) q_sl.push_back(cyc - log_base);
      if (cyc - log_base == 1)  seen_seed = o_seed_out;
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then check.
  task automatic step(input bit st, input bit ab, input bit r,
                      input int dv, input int ln, input logic [6:0] sd);
    bit b;
    rst         = r;
    i_start     = st;
    i_abort     = ab;
    i_div_ratio = dv[7:0];
    i_frame_len = ln[15:0];
    i_seed_in   = sd;
    if (m_act && cyc > frame_end()) m_act = 1'b0;
    b = m_busy(cyc);
    m_cfg = 1'b0;
    if (r) begin
      m_act = 1'b0;
    end else if (b) begin
      if (ab) m_act = 1'b0;
    end else if (st && !ab) begin
      if (dv != 0 && ln != 0) begin
        m_act  = 1'b1;
        m_t0   = cyc;
        m_div  = dv;
        m_len  = ln;
        m_seed = sd;
      end else begin
        m_cfg = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 20)),
           7'($urandom_range(0, 127)));
  endtask

  task automatic log_start();
    log_on   = 1'b1;
    log_base = cyc;
    q_ben.delete();
    q_done.delete();
    q_sl.delete();
  endtask

  initial begin
    int e_ben[$];
    int e_done[$];
    int e_sl[$];
    bit st, ab, r;
    int dv, ln;

    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_div_ratio = '0; i_frame_len = '0; i_seed_in = '0;
    step(1'b0, 1'b0, 1'b1, 0, 0, 7'h0);
    step(1'b0, 1'b0, 1'b1, 0, 0, 7'h0);
    idle(2);

    // div=4, len=3, seed 5A
    log_start();
    step(1'b1, 1'b0, 1'b0, 4, 3, 7'h5A);
    idle(16);
    e_ben = '{5, 9, 13}; e_done = '{14}; e_sl = '{1};
    lit("t1_bit_en_cycles", q_ben, e_ben);
    lit("t1_done_cycle", q_done, e_done);
    lit("t1_seed_load_cycle", q_sl, e_sl);
    chk("t1_seed_out", 32'(seen_seed), 32'h5A);

    // div=1, len=2, back-to-back restart right after done
    log_start();
    step(1'b1, 1'b0, 1'b0, 1, 2, 7'h11);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 2, 1, 7'h22);
    idle(6);
    e_ben = '{2, 3, 8}; e_done = '{4, 9}; e_sl = '{1, 6};
    lit("t2_bit_en_cycles", q_ben, e_ben);
    lit("t2_done_cycles", q_done, e_done);
    lit("t2_seed_load_cycles", q_sl, e_sl);
    log_on = 1'b0;

    // invalid configs
    step(1'b1, 1'b0, 1'b0, 0, 5, 7'h33);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 3, 0, 7'h44);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 3, 2, 7'h45);
    idle(2);

    // abort mid-frame, then full frame
    step(1'b1, 1'b0, 1'b0, 3, 10, 7'h55);
    idle(7);
    step(1'b0, 1'b1, 1'b0, 0, 0, 7'h0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 3, 10, 7'h66);
    idle(34);

    // restarts while busy are ignored
    log_start();
    step(1'b1, 1'b0, 1'b0, 4, 3, 7'h5A);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1, 9, 7'h01);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 2, 7, 7'h02);
    idle(10);
    e_ben = '{5, 9, 13}; e_done = '{14}; e_sl = '{1};
    lit("t5_bit_en_cycles", q_ben, e_ben);
    lit("t5_done_cycle", q_done, e_done);
    lit("t5_seed_load_cycle", q_sl, e_sl);
    log_on = 1'b0;

    // reset mid-frame
    step(1'b1, 1'b0, 1'b0, 3, 10, 7'h77);
    idle(6);
    step(1'b0, 1'b0, 1'b1, 0, 0, 7'h0);
    idle(3);

    // widest divider, shortest frame
    step(1'b1, 1'b0, 1'b0, 255, 1, 7'h7F);
    idle(260);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      dv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
      step(st, ab, r, dv, ln, 7'($urandom_range(0, 127)));
    end
    idle(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
